// File: rtl/vr_log_mem_ctrl.sv
// Log-memory responder: zero-initialised single-port log RAM, in-place writes with
// priority over reads, reads returned in order through a 3-entry response FIFO.
module vr_log_mem_ctrl #(
    parameter int LOG_IDX_W = 6,
    parameter int ENTRY_W   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 commit_log_mem_rd_req_val,
    input  logic [LOG_IDX_W-1:0] commit_log_mem_rd_req_addr,
    output logic                 log_mem_commit_rd_req_rdy,
    output logic                 log_mem_commit_rd_resp_val,
    output logic [ENTRY_W-1:0]   log_mem_commit_rd_resp_data,
    input  logic                 commit_log_mem_rd_resp_rdy,
    input  logic                 commit_log_mem_wr_val,
    input  logic [LOG_IDX_W-1:0] commit_log_mem_wr_addr,
    input  logic [ENTRY_W-1:0]   commit_log_mem_wr_data,
    output logic                 log_mem_commit_wr_rdy,
    output logic                 log_mem_init_done
);

    // state    | meaning
    // ST_INIT  | init_ptr sweeps the RAM writing zero; all rdy outputs low
    // ST_RUN   | serving reads and writes; terminal until rst
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam int DEPTH = 1 << LOG_IDX_W;

    logic [0:0]           state_q, state_d;
    logic [LOG_IDX_W-1:0] init_ptr_q, init_ptr_d;
    logic [1:0]           occ_q, occ_d;
    logic                 push_q;
    logic [ENTRY_W-1:0]   rd_data_q;
    logic [ENTRY_W-1:0]   fifo_q [3];
    logic [1:0]           wr_ptr_q, rd_ptr_q, cnt_q;
    logic [ENTRY_W-1:0]   mem [DEPTH];

    logic                 run, wr_fire, rd_fire, pop, mem_we;
    logic [LOG_IDX_W-1:0] mem_waddr;
    logic [ENTRY_W-1:0]   mem_wdata;

    assign run     = (state_q == ST_RUN);
    assign wr_fire = commit_log_mem_wr_val & run;
    // Write priority keys off wr_val so a write always wins the single RAM port.
    assign log_mem_commit_rd_req_rdy  = run & ~commit_log_mem_wr_val & (occ_q < 2'd3);
    assign log_mem_commit_wr_rdy      = run;
    assign log_mem_init_done          = run;
    assign rd_fire = commit_log_mem_rd_req_val & log_mem_commit_rd_req_rdy;
    assign log_mem_commit_rd_resp_val  = (cnt_q != 2'd0);
    assign log_mem_commit_rd_resp_data = fifo_q[rd_ptr_q];
    assign pop = log_mem_commit_rd_resp_val & commit_log_mem_rd_resp_rdy;

    assign mem_we    = ~rst & (~run | wr_fire);
    assign mem_waddr = run ? commit_log_mem_wr_addr : init_ptr_q;
    assign mem_wdata = run ? commit_log_mem_wr_data : '0;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end else if (rd_fire) begin
            rd_data_q <= mem[commit_log_mem_rd_req_addr];
        end
    end

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        if (state_q == ST_INIT) begin
            init_ptr_d = init_ptr_q + 1'b1;
            if (init_ptr_q == {LOG_IDX_W{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
        occ_d = occ_q + {1'b0, rd_fire} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            occ_q      <= occ_d;
        end
    end

    // push_q marks rd_data_q as holding a freshly fetched entry for the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            push_q   <= 1'b0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            push_q <= rd_fire;
            if (push_q) begin
                fifo_q[wr_ptr_q] <= rd_data_q;
                wr_ptr_q         <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
            end
            cnt_q <= cnt_q + {1'b0, push_q} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_vr_log_mem_ctrl.sv
// Directed bench for vr_log_mem_ctrl: init sweep, write/read, streaming,
// backpressure, write/read collision and mid-stream reset.
module tb_vr_log_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_val;
    logic [5:0]  rd_addr;
    logic        rd_rdy;
    logic        resp_val;
    logic [63:0] resp_data;
    logic        resp_rdy;
    logic        wr_val;
    logic [5:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_rdy;
    logic        init_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vr_log_mem_ctrl #(.LOG_IDX_W(6), .ENTRY_W(64)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .commit_log_mem_rd_req_val   (rd_val),
        .commit_log_mem_rd_req_addr  (rd_addr),
        .log_mem_commit_rd_req_rdy   (rd_rdy),
        .log_mem_commit_rd_resp_val  (resp_val),
        .log_mem_commit_rd_resp_data (resp_data),
        .commit_log_mem_rd_resp_rdy  (resp_rdy),
        .commit_log_mem_wr_val       (wr_val),
        .commit_log_mem_wr_addr      (wr_addr),
        .commit_log_mem_wr_data      (wr_data),
        .log_mem_commit_wr_rdy       (wr_rdy),
        .log_mem_init_done           (init_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [63:0] d);
        wr_val = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_val = 1'b0;
    endtask

    // Issues one read, checks acceptance, 2-cycle latency and data, then pops it.
    task automatic do_read_expect(input string name, input logic [5:0] a, input logic [63:0] exp);
        resp_rdy = 1'b0; rd_val = 1'b1; rd_addr = a;
        #2;
        checks++;
        if (rd_rdy !== 1'b1) begin failures++; $display("FAIL %s accept: rd_rdy=%b want 1", name, rd_rdy); end
        tick();
        rd_val = 1'b0;
        #2;
        checks++;
        if (resp_val !== 1'b0) begin failures++; $display("FAIL %s early: resp_val=%b want 0", name, resp_val); end
        tick();
        #2;
        checks++;
        if (resp_val !== 1'b1 || resp_data !== exp) begin
            failures++;
            $display("FAIL %s resp: val=%b data=%h want val=1 data=%h", name, resp_val, resp_data, exp);
        end
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        #2;
        checks++;
        if (resp_val !== 1'b0) begin failures++; $display("FAIL %s pop: resp_val=%b want 0", name, resp_val); end
    endtask

    task automatic check_init_window(input string name);
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            #2;
            if (rd_rdy !== 1'b0 || wr_rdy !== 1'b0 || init_done !== 1'b0 || resp_val !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL %s init_low: bad_cycles=%0d want 0", name, bad); end
        #2;
        checks++;
        if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1 || init_done !== 1'b1) begin
            failures++;
            $display("FAIL %s init_end: rd_rdy=%b wr_rdy=%b done=%b want 1 1 1", name, rd_rdy, wr_rdy, init_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #2;
        checks++;
        if (resp_data !== 64'd0 || resp_val !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: resp_val=%b data=%h want 0 0", resp_val, resp_data);
        end
        check_init_window("reset");
        do_read_expect("init_rd37", 6'd37, 64'd0);
    endtask

    task automatic test_write_read();
        do_write(6'd5, 64'hDEAD_BEEF_0000_0005);
        do_read_expect("wr_rd5", 6'd5, 64'hDEAD_BEEF_0000_0005);
    endtask

    task automatic test_streaming();
        int rdy_drops = 0;
        int bad_resp  = 0;
        for (int i = 0; i < 16; i++) do_write(6'(i), 64'(i));
        resp_rdy = 1'b1;
        for (int c = 0; c < 19; c++) begin
            rd_val  = (c < 16);
            rd_addr = 6'(c);
            #2;
            if (c < 16 && rd_rdy !== 1'b1) rdy_drops++;
            if (c >= 2 && c < 18) begin
                if (resp_val !== 1'b1 || resp_data !== 64'(c - 2)) bad_resp++;
            end else if (resp_val !== 1'b0) begin
                bad_resp++;
            end
            tick();
        end
        rd_val = 1'b0; resp_rdy = 1'b0;
        checks++;
        if (rdy_drops != 0) begin failures++; $display("FAIL stream_rdy: drops=%0d want 0", rdy_drops); end
        checks++;
        if (bad_resp != 0) begin failures++; $display("FAIL stream_resp: bad_cycles=%0d want 0", bad_resp); end
    endtask

    task automatic test_backpressure();
        int issued = 0;
        int got    = 0;
        int bad    = 0;
        resp_rdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            rd_val = 1'b1; rd_addr = 6'(issued + 1);
            #2;
            if (rd_rdy === 1'b1) issued++;
            tick();
        end
        #2;
        checks++;
        if (issued != 3 || rd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept: accepted=%0d rd_rdy=%b want 3 0", issued, rd_rdy);
        end
        resp_rdy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            rd_val  = (issued < 5);
            rd_addr = 6'(issued + 1);
            #2;
            if (resp_val === 1'b1) begin
                if (resp_data !== 64'(got + 1)) bad++;
                got++;
            end
            if (rd_val && rd_rdy === 1'b1) issued++;
            tick();
        end
        rd_val = 1'b0; resp_rdy = 1'b0;
        checks++;
        if (got != 5 || bad != 0) begin
            failures++;
            $display("FAIL bp_drain: responses=%0d out_of_order=%0d want 5 0", got, bad);
        end
    endtask

    task automatic test_collision();
        rd_val = 1'b1; rd_addr = 6'd9;
        wr_val = 1'b1; wr_addr = 6'd9; wr_data = 64'h1234;
        #2;
        checks++;
        if (wr_rdy !== 1'b1 || rd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL collide_rdy: wr_rdy=%b rd_rdy=%b want 1 0", wr_rdy, rd_rdy);
        end
        tick();
        wr_val = 1'b0;
        do_read_expect("collide_rd9", 6'd9, 64'h1234);
    endtask

    task automatic test_reset_mid();
        do_write(6'd5, 64'h0000_0000_0000_AAAA);
        resp_rdy = 1'b0;
        rd_val = 1'b1; rd_addr = 6'd1; tick();
        rd_addr = 6'd2; tick();
        rd_val = 1'b0; tick();
        #2;
        checks++;
        if (resp_val !== 1'b1) begin failures++; $display("FAIL mid_buffered: resp_val=%b want 1", resp_val); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        checks++;
        if (resp_val !== 1'b0 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst: resp_val=%b done=%b want 0 0", resp_val, init_done);
        end
        check_init_window("mid");
        do_read_expect("mid_rd5", 6'd5, 64'd0);
    endtask

    initial begin
        rst = 1'b1; rd_val = 1'b0; rd_addr = '0; resp_rdy = 1'b0;
        wr_val = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset();
        test_write_read();
        test_streaming();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
